// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package mips_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2
  } arb_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [3:0] INST_ARLEN     = 4'd1;
  localparam logic [3:0] DATA_ARLEN     = 4'd0;
  localparam logic [3:0] DEF_INST_ID    = 4'd0;
  localparam logic [3:0] DEF_DATA_ID    = 4'd1;

endpackage

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 = fetch, bit 1 = data.
// On a conflict the side that was not granted last wins; the history
// register starts at "fetch" so data wins the first conflict.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic       last_data_r;
  logic [1:0] gnt_s;

  // Grant selection: single requester wins outright, conflicts alternate.
  always_comb begin
    gnt_s = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = last_data_r ? 2'b01 : 2'b10;
        default: gnt_s = 2'b00;
      endcase
    end else begin
      gnt_s = 2'b00;
    end
  end

  // Remember which side received the most recent grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_data_r <= 1'b0;
    end else if (en && (req != 2'b00)) begin
      last_data_r <= gnt_s[1];
    end else begin
      last_data_r <= last_data_r;
    end
  end

  assign gnt = gnt_s;

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between instruction fetch (2-beat bursts)
// and data loads (single beat). One transaction in flight at a time;
// returning beats are steered by the latched owner, not by rid.
module axi_rd_arbiter
  import mips_axi_pkg::*;
#(
  parameter logic [3:0] INST_ID = DEF_INST_ID,
  parameter logic [3:0] DATA_ID = DEF_DATA_ID
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cancel,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  output logic        inst_last,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        arvalid,
  output logic [31:0] araddr,
  output logic [3:0]  arid,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  input  logic        arready,
  input  logic        rvalid,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  output logic        rready
);

  arb_state_e  state_r;
  logic        owner_data_r;
  logic        drop_r;
  logic        arvalid_r;
  logic        rready_r;
  logic [31:0] araddr_r;
  logic [3:0]  arid_r;
  logic [3:0]  arlen_r;
  logic [2:0]  arsize_r;
  logic [1:0]  arburst_r;
  logic        grant_en_s;
  logic [1:0]  gnt_s;
  logic        inst_data_ok_s;
  logic        inst_last_s;
  logic        data_data_ok_s;
  logic        unused_rid_s;

  // Returning beats are routed by owner only; rid is deliberately ignored.
  assign unused_rid_s = ^rid;

  // Grants only in IDLE, and never while reset is asserted.
  assign grant_en_s = (state_r == ST_IDLE) && !reset;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .en    (grant_en_s),
    .req   ({data_req, inst_req}),
    .gnt   (gnt_s)
  );

  // Zero-latency steering of R beats to the owning requester.
  always_comb begin
    inst_data_ok_s = 1'b0;
    inst_last_s    = 1'b0;
    data_data_ok_s = 1'b0;
    if (rready_r && rvalid) begin
      if (owner_data_r) begin
        data_data_ok_s = 1'b1;
      end else if (!drop_r && !inst_cancel) begin
        inst_data_ok_s = 1'b1;
        inst_last_s    = rlast;
      end else begin
        inst_data_ok_s = 1'b0;
      end
    end else begin
      data_data_ok_s = 1'b0;
    end
  end

  // Transaction FSM: grant and latch AR fields, hold AR until accepted,
  // then consume beats until rlast. A fetch cancel only marks beats as dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      owner_data_r <= 1'b0;
      drop_r       <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      araddr_r     <= 32'd0;
      arid_r       <= 4'd0;
      arlen_r      <= 4'd0;
      arsize_r     <= 3'd0;
      arburst_r    <= 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          drop_r <= 1'b0;
          if (gnt_s[1]) begin
            owner_data_r <= 1'b1;
            araddr_r     <= data_addr;
            arid_r       <= DATA_ID;
            arlen_r      <= DATA_ARLEN;
            arsize_r     <= data_size;
            arburst_r    <= AXI_BURST_INCR;
            arvalid_r    <= 1'b1;
            state_r      <= ST_AR;
          end else if (gnt_s[0]) begin
            owner_data_r <= 1'b0;
            araddr_r     <= inst_addr;
            arid_r       <= INST_ID;
            arlen_r      <= INST_ARLEN;
            arsize_r     <= AXI_SIZE_WORD;
            arburst_r    <= AXI_BURST_INCR;
            arvalid_r    <= 1'b1;
            state_r      <= ST_AR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_AR: begin
          if (inst_cancel && !owner_data_r) begin
            drop_r <= 1'b1;
          end
          if (arready) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            state_r   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid && rlast) begin
            rready_r <= 1'b0;
            drop_r   <= 1'b0;
            state_r  <= ST_IDLE;
          end else if (inst_cancel && !owner_data_r) begin
            drop_r <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          drop_r    <= 1'b0;
        end
      endcase
    end
  end

  assign inst_addr_ok = gnt_s[0];
  assign data_addr_ok = gnt_s[1];
  assign inst_data_ok = inst_data_ok_s;
  assign inst_last    = inst_last_s;
  assign inst_rdata   = rdata;
  assign data_data_ok = data_data_ok_s;
  assign data_rdata   = rdata;
  assign arvalid      = arvalid_r;
  assign araddr       = araddr_r;
  assign arid         = arid_r;
  assign arlen        = arlen_r;
  assign arsize       = arsize_r;
  assign arburst      = arburst_r;
  assign rready       = rready_r;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus a
// randomized run against a round-robin/transaction reference model.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0, inst_cancel = 1'b0, data_req = 1'b0;
  logic [31:0] inst_addr = 32'd0, data_addr = 32'd0;
  logic [2:0]  data_size = 3'd0;
  logic        inst_addr_ok, inst_data_ok, inst_last, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        arvalid, rready;
  logic [31:0] araddr;
  logic [3:0]  arid, arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [3:0]  rid = 4'd0;
  logic [31:0] rdata = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: 1 when the last grant went to data.
  bit m_last_data = 1'b0;

  // Observations recorded by the transaction driver.
  int          o_gnt, o_gcyc, o_acc_cyc, o_first_beat_cyc, o_last_beat_cyc;
  int          o_inst_ok, o_data_ok;
  bit          o_ar_stable, o_rready_all;
  logic [31:0] o_araddr;
  logic [3:0]  o_arid, o_arlen;
  logic [2:0]  o_arsize;
  logic [1:0]  o_arburst;
  logic [1:0]  o_last_mask;
  logic [31:0] o_words [2];

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata), .inst_last(inst_last),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arvalid(arvalid), .araddr(araddr), .arid(arid), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arready(arready),
    .rvalid(rvalid), .rid(rid), .rdata(rdata), .rlast(rlast), .rready(rready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: which side the arbiter should grant (1 = inst, 2 = data).
  function automatic int predict(input bit ireq, input bit dreq);
    if (ireq && dreq) return m_last_data ? 1 : 2;
    else if (dreq) return 2;
    else if (ireq) return 1;
    else return 0;
  endfunction

  // Drives one request and plays the AXI slave; records what the DUT did.
  task automatic txn(input bit ireq, input bit dreq, input logic [31:0] ia,
                     input logic [31:0] da, input logic [2:0] ds, input int arw,
                     input logic [31:0] w0, input logic [31:0] w1, input bit cancel_mid);
    int n, nb;
    o_gnt = 0; o_inst_ok = 0; o_data_ok = 0; o_ar_stable = 1'b1; o_rready_all = 1'b1;
    o_last_mask = 2'b00; o_words[0] = 32'd0; o_words[1] = 32'd0;
    @(negedge clk);
    inst_req = ireq; data_req = dreq; inst_addr = ia; data_addr = da; data_size = ds;
    n = 0;
    #1;
    while (!(inst_addr_ok || data_addr_ok) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!(inst_addr_ok || data_addr_ok)) begin
      $display("FAIL grant_timeout: no addr_ok after %0d cycles, required a grant", n);
      inst_req = 1'b0; data_req = 1'b0;
      return;
    end
    o_gnt  = (inst_addr_ok ? 1 : 0) + (data_addr_ok ? 2 : 0);
    o_gcyc = cyc;
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk); #1;
    o_araddr = araddr; o_arid = arid; o_arlen = arlen; o_arsize = arsize; o_arburst = arburst;
    if (!arvalid) o_ar_stable = 1'b0;
    for (int i = 0; i < arw; i++) begin
      @(negedge clk); #1;
      if (!arvalid || araddr !== o_araddr || arid !== o_arid || arlen !== o_arlen ||
          arsize !== o_arsize || arburst !== o_arburst) o_ar_stable = 1'b0;
    end
    arready = 1'b1; o_acc_cyc = cyc;
    @(posedge clk); #1;
    arready = 1'b0;
    nb = (o_gnt == 1) ? 2 : 1;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      if (b == 1 && cancel_mid) begin
        inst_cancel = 1'b1;
        @(negedge clk);
        inst_cancel = 1'b0;
      end
      rvalid = 1'b1; rlast = (b == nb - 1); rdata = (b == 0) ? w0 : w1;
      rid = (o_gnt == 1) ? 4'd0 : 4'd1;
      #1;
      if (b == 0) o_first_beat_cyc = cyc;
      o_last_beat_cyc = cyc;
      if (!rready) o_rready_all = 1'b0;
      o_last_mask[b] = inst_last;
      if (inst_data_ok) begin o_inst_ok++; o_words[b] = inst_rdata; end
      if (data_data_ok) begin o_data_ok++; o_words[b] = data_rdata; end
      @(posedge clk); #1;
      rvalid = 1'b0; rlast = 1'b0;
    end
  endtask

  task automatic test_reset;
    #2;
    n_checks++;
    if ({arvalid, rready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, inst_last} !== 7'd0 ||
        {araddr, arid, arlen, arsize, arburst} !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_values: arvalid=%b rready=%b araddr=%h arid=%h arlen=%h arsize=%h arburst=%h, required all 0",
               arvalid, rready, araddr, arid, arlen, arsize, arburst);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_last_data = 1'b0;
    #1;
    n_checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: arvalid=%b rready=%b, required 0 0", arvalid, rready);
    end
  endtask

  task automatic test_conflict;
    int exp;
    for (int k = 0; k < 3; k++) begin
      exp = predict(1'b1, 1'b1);
      txn(1'b1, 1'b1, 32'h0000_1000, 32'h0000_2000, 3'd2, 0, 32'h11, 32'h22, 1'b0);
      n_checks++;
      if (o_gnt !== exp) begin
        n_fail++;
        $display("FAIL conflict_grant%0d: got side %0d, required %0d", k, o_gnt, exp);
      end
      m_last_data = (exp == 2);
    end
  endtask

  task automatic test_fetch;
    txn(1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 3'd0, 0, 32'h2401_0001, 32'h2402_0002, 1'b0);
    m_last_data = 1'b0;
    n_checks++;
    if (o_gnt !== 1 || o_araddr !== 32'hBFC0_0000) begin
      n_fail++; $display("FAIL fetch_grant: side=%0d araddr=%h, required 1 bfc00000", o_gnt, o_araddr);
    end
    n_checks++;
    if (o_arlen !== 4'd1 || o_arsize !== 3'd2 || o_arburst !== 2'd1 || o_arid !== 4'd0) begin
      n_fail++; $display("FAIL fetch_ar_fields: arlen=%0d arsize=%0d arburst=%0d arid=%0d, required 1 2 1 0",
                         o_arlen, o_arsize, o_arburst, o_arid);
    end
    n_checks++;
    if (o_inst_ok !== 2 || o_data_ok !== 0 || o_last_mask !== 2'b10) begin
      n_fail++; $display("FAIL fetch_beats: inst_ok=%0d data_ok=%0d last_mask=%b, required 2 0 10",
                         o_inst_ok, o_data_ok, o_last_mask);
    end
    n_checks++;
    if (o_words[0] !== 32'h2401_0001 || o_words[1] !== 32'h2402_0002) begin
      n_fail++; $display("FAIL fetch_data: %h %h, required 24010001 24020002", o_words[0], o_words[1]);
    end
  endtask

  task automatic test_load;
    int prev_last;
    prev_last = o_last_beat_cyc;
    txn(1'b0, 1'b1, 32'h0, 32'h8000_1004, 3'd2, 0, 32'hCAFE_F00D, 32'h0, 1'b0);
    m_last_data = 1'b1;
    n_checks++;
    if (o_gcyc !== prev_last + 1) begin
      n_fail++; $display("FAIL idle_after_rlast: grant cycle %0d, required %0d", o_gcyc, prev_last + 1);
    end
    n_checks++;
    if (o_gnt !== 2 || o_araddr !== 32'h8000_1004 || o_arlen !== 4'd0 || o_arid !== 4'd1 ||
        o_arsize !== 3'd2 || o_arburst !== 2'd1) begin
      n_fail++; $display("FAIL load_ar_fields: side=%0d araddr=%h arlen=%0d arid=%0d arsize=%0d arburst=%0d, required 2 80001004 0 1 2 1",
                         o_gnt, o_araddr, o_arlen, o_arid, o_arsize, o_arburst);
    end
    n_checks++;
    if (o_data_ok !== 1 || o_inst_ok !== 0 || o_words[0] !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL load_beat: data_ok=%0d inst_ok=%0d word=%h, required 1 0 cafef00d",
                         o_data_ok, o_inst_ok, o_words[0]);
    end
  endtask

  task automatic test_ar_stall;
    txn(1'b0, 1'b1, 32'h0, 32'h8000_2000, 3'd1, 5, 32'h0000_BEEF, 32'h0, 1'b0);
    m_last_data = 1'b1;
    n_checks++;
    if (o_ar_stable !== 1'b1) begin
      n_fail++; $display("FAIL ar_stall_stable: stable=%b, required 1", o_ar_stable);
    end
    n_checks++;
    if (o_acc_cyc - o_gcyc !== 6 || o_arsize !== 3'd1) begin
      n_fail++; $display("FAIL ar_stall_accept: accept at +%0d arsize=%0d, required +6 1", o_acc_cyc - o_gcyc, o_arsize);
    end
    n_checks++;
    if (o_data_ok !== 1 || o_words[0] !== 32'h0000_BEEF) begin
      n_fail++; $display("FAIL ar_stall_beat: data_ok=%0d word=%h, required 1 0000beef", o_data_ok, o_words[0]);
    end
  endtask

  task automatic test_back_to_back;
    int g0, b0;
    txn(1'b0, 1'b1, 32'h0, 32'h8000_3000, 3'd2, 0, 32'h1234_5678, 32'h0, 1'b0);
    g0 = o_gcyc; b0 = o_first_beat_cyc;
    txn(1'b0, 1'b1, 32'h0, 32'h8000_3004, 3'd2, 0, 32'h9ABC_DEF0, 32'h0, 1'b0);
    m_last_data = 1'b1;
    n_checks++;
    if (b0 - g0 !== 2) begin
      n_fail++; $display("FAIL min_latency_data: data_ok at +%0d, required +2", b0 - g0);
    end
    n_checks++;
    if (o_gcyc - g0 !== 3 || o_gnt !== 2) begin
      n_fail++; $display("FAIL min_latency_regrant: next grant at +%0d side=%0d, required +3 2", o_gcyc - g0, o_gnt);
    end
  endtask

  task automatic test_cancel;
    int prev_last;
    txn(1'b1, 1'b0, 32'hBFC0_0100, 32'h0, 3'd0, 0, 32'hAAAA_0001, 32'hAAAA_0002, 1'b1);
    m_last_data = 1'b0;
    prev_last = o_last_beat_cyc;
    n_checks++;
    if (o_inst_ok !== 1 || o_words[0] !== 32'hAAAA_0001 || o_last_mask !== 2'b00) begin
      n_fail++; $display("FAIL cancel_drop: inst_ok=%0d word0=%h last_mask=%b, required 1 aaaa0001 00",
                         o_inst_ok, o_words[0], o_last_mask);
    end
    n_checks++;
    if (o_rready_all !== 1'b1) begin
      n_fail++; $display("FAIL cancel_consume: rready on all beats=%b, required 1", o_rready_all);
    end
    txn(1'b0, 1'b1, 32'h0, 32'h8000_4000, 3'd2, 0, 32'h5555_AAAA, 32'h0, 1'b0);
    m_last_data = 1'b1;
    n_checks++;
    if (o_gnt !== 2 || o_gcyc !== prev_last + 1 || o_data_ok !== 1) begin
      n_fail++; $display("FAIL cancel_then_load: side=%0d grant cycle=%0d data_ok=%0d, required 2 %0d 1",
                         o_gnt, o_gcyc, o_data_ok, prev_last + 1);
    end
  endtask

  task automatic test_random;
    bit ir, dr;
    int exp;
    logic [31:0] ia, da, w0, w1;
    logic [2:0]  ds;
    for (int k = 0; k < 30; k++) begin
      ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) dr = 1'b1;
      ia = $urandom(); ia[1:0] = 2'b00;
      da = $urandom(); ds = 3'($urandom_range(0, 2));
      w0 = $urandom(); w1 = $urandom();
      exp = predict(ir, dr);
      txn(ir, dr, ia, da, ds, $urandom_range(0, 3), w0, w1, 1'b0);
      n_checks++;
      if (o_gnt !== exp) begin
        n_fail++; $display("FAIL rand_grant[%0d]: side=%0d, required %0d", k, o_gnt, exp);
      end
      m_last_data = (exp == 2);
      n_checks++;
      if (exp == 1) begin
        if (o_araddr !== ia || o_arlen !== 4'd1 || o_arsize !== 3'd2 || o_arid !== 4'd0 ||
            o_inst_ok !== 2 || o_words[0] !== w0 || o_words[1] !== w1 || o_last_mask !== 2'b10) begin
          n_fail++; $display("FAIL rand_fetch[%0d]: araddr=%h arlen=%0d ok=%0d words=%h %h, required %h 1 2 %h %h",
                             k, o_araddr, o_arlen, o_inst_ok, o_words[0], o_words[1], ia, w0, w1);
        end
      end else begin
        if (o_araddr !== da || o_arlen !== 4'd0 || o_arsize !== ds || o_arid !== 4'd1 ||
            o_data_ok !== 1 || o_inst_ok !== 0 || o_words[0] !== w0) begin
          n_fail++; $display("FAIL rand_load[%0d]: araddr=%h arsize=%0d ok=%0d word=%h, required %h %0d 1 %h",
                             k, o_araddr, o_arsize, o_data_ok, o_words[0], da, ds, w0);
        end
      end
    end
  endtask

  task automatic test_reset_in_r;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_0200;
    @(posedge clk); #1; inst_req = 1'b0;
    @(negedge clk); arready = 1'b1;
    @(posedge clk); #1; arready = 1'b0;
    @(negedge clk);
    rvalid = 1'b1; rdata = 32'h7777_0001; rlast = 1'b0;
    #1;
    n_checks++;
    if (rready !== 1'b1 || inst_data_ok !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_r_setup: rready=%b inst_data_ok=%b, required 1 1", rready, inst_data_ok);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({arvalid, rready, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, inst_last} !== 7'd0 ||
        {araddr, arid, arlen, arsize, arburst} !== 45'd0) begin
      n_fail++; $display("FAIL reset_in_r: rready=%b inst_data_ok=%b araddr=%h arlen=%h arsize=%h, required all 0",
                         rready, inst_data_ok, araddr, arlen, arsize);
    end
    rvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_last_data = 1'b0;
  endtask

  initial begin
    test_reset();
    test_conflict();
    test_fetch();
    test_load();
    test_ar_stall();
    test_back_to_back();
    test_cancel();
    test_random();
    test_reset_in_r();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
